// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one asynchronous-read memory between the CPU bus and a
// host (debug/loader) port. The CPU path passes straight through with absolute
// priority. A single host command is queued and issued only in a cycle where
// neither CPU strobe is high. A sticky flag reports host commands that have
// been blocked for MAX_WAIT cycles.
//
// Ports:
//   i_clk, i_rst                         clock, synchronous active-high reset
//   i_cpu_rd/wr/addr/wdata, o_cpu_rdata  CPU bus (o_cpu_rdata = i_mem_rdata)
//   i_host_req/we/addr/wdata             host command, held until o_host_ack
//   o_host_ack, o_host_rdata             registered completion pulse and data
//   o_host_starve                        sticky starvation flag
//   o_mem_rd/wr/addr/wdata, i_mem_rdata  memory port (mux output is combinational)
module mem_arbiter #(
    parameter int unsigned AW       = 5,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cpu_rd,
    input  logic          i_cpu_wr,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic [DW-1:0] o_cpu_rdata,
    input  logic          i_host_req,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_wdata,
    output logic          o_host_ack,
    output logic [DW-1:0] o_host_rdata,
    output logic          o_host_starve,
    output logic          o_mem_rd,
    output logic          o_mem_wr,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    // MAX_WAIT is at most 255, so an 8-bit counter always reaches it.
    localparam int unsigned CW = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_we_p;
    logic [AW-1:0]   r_addr_p;
    logic [DW-1:0]   r_wdata_p;
    logic            r_ack;
    logic [DW-1:0]   r_rdata;
    logic            r_starve;
    logic [CW-1:0]   r_wait_cnt;

    state_t          w_state_next;
    logic            w_we_next;
    logic [AW-1:0]   w_addr_next;
    logic [DW-1:0]   w_wdata_next;
    logic            w_ack_next;
    logic [DW-1:0]   w_rdata_next;
    logic            w_starve_next;
    logic [CW-1:0]   w_wait_next;
    logic            w_cpu_act;

    assign w_cpu_act = i_cpu_rd | i_cpu_wr;

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_we_p     <= 1'b0;
            r_addr_p   <= '0;
            r_wdata_p  <= '0;
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_starve   <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_we_p     <= w_we_next;
            r_addr_p   <= w_addr_next;
            r_wdata_p  <= w_wdata_next;
            r_ack      <= w_ack_next;
            r_rdata    <= w_rdata_next;
            r_starve   <= w_starve_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    // Next-state: accept in IDLE, issue in PEND on a free slot, otherwise count.
    always_comb begin
        w_state_next  = r_state;
        w_we_next     = r_we_p;
        w_addr_next   = r_addr_p;
        w_wdata_next  = r_wdata_p;
        w_ack_next    = 1'b0;
        w_rdata_next  = r_rdata;
        w_starve_next = r_starve;
        w_wait_next   = r_wait_cnt;

        case (r_state)
            ST_IDLE: begin
                if (i_host_req) begin
                    w_we_next    = i_host_we;
                    w_addr_next  = i_host_addr;
                    w_wdata_next = i_host_wdata;
                    w_state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!w_cpu_act) begin
                    // Issue cycle: memory is driven by the pending command now.
                    w_ack_next = 1'b1;
                    if (!r_we_p) begin
                        w_rdata_next = i_mem_rdata;
                    end
                    w_wait_next  = '0;
                    w_state_next = ST_IDLE;
                end else if (r_wait_cnt < CW'(MAX_WAIT)) begin
                    // Counter saturates at MAX_WAIT; flag sets on reaching it.
                    w_wait_next = r_wait_cnt + CW'(1);
                    if (w_wait_next == CW'(MAX_WAIT)) begin
                        w_starve_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Memory mux: CPU first, then pending host command, else idle strobes.
    always_comb begin
        o_mem_rd    = 1'b0;
        o_mem_wr    = 1'b0;
        o_mem_addr  = i_cpu_addr;
        o_mem_wdata = i_cpu_wdata;
        if (w_cpu_act) begin
            o_mem_rd = i_cpu_rd;
            o_mem_wr = i_cpu_wr;
        end else if (r_state == ST_PEND) begin
            o_mem_rd    = ~r_we_p;
            o_mem_wr    = r_we_p;
            o_mem_addr  = r_addr_p;
            o_mem_wdata = r_wdata_p;
        end
    end

    assign o_cpu_rdata   = i_mem_rdata;
    assign o_host_ack    = r_ack;
    assign o_host_rdata  = r_rdata;
    assign o_host_starve = r_starve;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single program/data memory between the CPU controller's fetch/execute bus and a host (debug/program-loader) port. The CPU path has absolute priority and passes through combinationally, so CPU cycle timing is never disturbed. Host transactions are queued and issued only in cycles where the CPU drives neither `rd` nor `wr`. A sticky starvation flag reports host requests that wait too long for a free slot.

## Interface
- `AW`, 5: address width.
- `DW`, 8: data width.
- `MAX_WAIT`, 15: number of PEND cycles without a free slot before `host_starve` sets. Range 1..255.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_rd`  in  1  CPU memory read request (level, per cycle).
- `cpu_wr`  in  1  CPU memory write request (level, per cycle).
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_rdata`  out  DW  memory read data to CPU; equals `mem_rdata` combinationally.
- `host_req`  in  1  host transaction request; command must be stable while high until `host_ack`.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  AW  host address.
- `host_wdata`  in  DW  host write data.
- `host_ack`  out  1  registered one-cycle completion pulse.
- `host_rdata`  out  DW  registered read data, valid while `host_ack` is high; held afterwards.
- `host_starve`  out  1  sticky flag; cleared only by `rst`.
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data; asynchronous read, valid in the same cycle as `mem_addr`.

## Operation
- FSM states: IDLE, PEND.
- IDLE
  - If `host_req`=1, latch `host_we`, `host_addr` and `host_wdata` into pending registers, then go to PEND.
  - Otherwise stay in IDLE.
- PEND, with `cpu_rd`=0 and `cpu_wr`=0 (a free slot; this is the issue cycle):
  - Drive the pending command onto memory: `mem_rd` = ~we_p, `mem_wr` = we_p.
  - On the edge ending the cycle: `host_ack` <= 1; for a read, `host_rdata` <= `mem_rdata`; `wait_cnt` <= 0; go to IDLE.
- PEND, with the CPU active: stay in PEND and increment `wait_cnt`.
  - When `wait_cnt` reaches `MAX_WAIT`, set `host_starve` and saturate the counter.
  - The request is never dropped.
- Memory mux, in priority order:
  - If `cpu_rd` or `cpu_wr` is high, all `mem_*` outputs follow the `cpu_*` inputs.
  - Else, if in PEND, the `mem_*` outputs follow the pending registers.
  - Else, `mem_rd` = `mem_wr` = 0, and `mem_addr`/`mem_wdata` follow the `cpu_*` inputs.
- `cpu_rdata` = `mem_rdata` at all times.
- `host_ack` is high for exactly one cycle per accepted request.
- If `host_req` is still high in the ack cycle, it is accepted as a new transaction (the FSM is in IDLE). The host deasserts `host_req` in the ack cycle to avoid a repeat.
- `cpu_rd` and `cpu_wr` both high: both are forwarded unchanged. The arbiter does not check for this.
- Host write data is forwarded unchanged; no byte enables.

## Timing
- Reset values: FSM = IDLE; `host_ack` = 0; `host_rdata` = 0; `host_starve` = 0; `wait_cnt` = 0; pending registers = 0.
- `mem_*` outputs after reset: combinational as above, i.e. `mem_rd` = `mem_wr` = 0 unless the CPU is active.
- Minimum host latency:
  - `host_req` sampled at edge E0 → PEND during cycle 1.
  - If cycle 1 is a free slot, `host_ack` is high in cycle 2.
  - Total: 2 cycles from the request edge.
- Each CPU-active cycle in PEND adds one cycle of latency.
- CPU latency: zero added cycles; the memory access is in the same cycle as `cpu_rd`/`cpu_wr`.
- `host_starve` rises on the edge after the `MAX_WAIT`-th consecutive blocked PEND cycle.
- Reset mid-transaction (PEND or ack cycle): the request is discarded, no ack is produced, and `host_rdata` clears. The host must re-request.
- CPU and host never drive memory in the same cycle. The host issues only when both CPU strobes are 0.

## Test plan
- Host read while the CPU is idle:
  - Stimulus: memory[5]=8'hA3; `host_req`=1, `host_we`=0, `host_addr`=5 at edge 0; CPU strobes 0.
  - Required: `mem_rd`=1 with `mem_addr`=5 in cycle 1; `host_ack`=1 and `host_rdata`=8'hA3 in cycle 2.
- Host write blocked by the CPU:
  - Stimulus: host write of 8'h3C to addr 9; `cpu_rd`=1 for 4 cycles.
  - Required: `mem_wr`=0 during those 4 cycles; issue in the first cycle with `cpu_rd`=0; `host_ack` on the following cycle; memory[9]=8'h3C.
- CPU priority and pass-through:
  - Stimulus: `cpu_rd`=1, `cpu_addr`=2 at the same time as a pending host read of addr 7.
  - Required: `mem_addr`=2 and `cpu_rdata` = memory[2] in the same cycle; the host read is issued later.
- Starvation (`MAX_WAIT`=3):
  - Stimulus: hold `cpu_wr`=1 for 5 cycles with a host request pending.
  - Required: `host_starve`=1 after the 3rd blocked cycle; it stays 1 after the ack until `rst`.
- Back-to-back requests:
  - Stimulus: hold `host_req`=1 through the ack cycle.
  - Required: a second transaction is accepted and the next ack arrives exactly 2 cycles later (CPU idle).
- Reset in PEND:
  - Stimulus: assert `rst` for 1 cycle while PEND.
  - Required: no `host_ack`; FSM in IDLE; `host_rdata`=0; `host_starve`=0.
